router_port_driver: RTL and testbench

Upstream feeder for one input port of the 16-port router. Collects one packet as a byte stream over a valid/ready handshake, buffers it whole, then serializes it onto the router's per-port input protocol (`din`, `frame_n`, `valid_n`). Buffering the whole packet guarantees gap-free payload bits. One instance drives each router input port.

---
 rtl/router_port_driver.sv | 154 +++++++++++++++
 tb/tb_router_port_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/router_port_driver.sv
// Per-port feeder: buffers one whole packet from a byte stream, then serializes
// it as address, padding and gap-free payload onto the router input protocol.
module router_port_driver #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PAD_CYCLES = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic [3:0] in_da,
    output logic       din,
    output logic       frame_n,
    output logic       valid_n,
    output logic       busy,
    output logic       pkt_done,
    output logic       err_trunc
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] LOAD = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] PAD  = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [5:0] LAST_SLOT = 6'(DEPTH - 1);
    localparam logic [3:0] PAD_LAST  = 4'(PAD_CYCLES - 1);

    logic [2:0] state;
    logic [3:0] phase;
    logic [5:0] wr_idx;
    logic [5:0] rd_idx;
    logic [5:0] last_idx;
    logic [2:0] bit_idx;
    logic [3:0] da;
    logic [7:0] mem [0:(1 << AW) - 1];

    logic       accept;
    logic       closing;
    logic [5:0] nxt_idx;
    logic [2:0] nxt_bit;
    logic       final_bit;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign closing  = in_last || (wr_idx == LAST_SLOT);

    always_comb begin
        nxt_bit   = bit_idx + 3'd1;
        nxt_idx   = (bit_idx == 3'd7) ? rd_idx + 6'd1 : rd_idx;
        final_bit = (rd_idx == last_idx) && (bit_idx == 3'd7);
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_idx[AW-1:0]] <= in_data;
        end
    end

    // Serial outputs are loaded one cycle ahead from the next-state decision,
    // so the first address bit can use in_da directly on a one-byte packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            phase     <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            last_idx  <= '0;
            bit_idx   <= '0;
            da        <= '0;
            din       <= 1'b0;
            frame_n   <= 1'b1;
            valid_n   <= 1'b1;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            pkt_done  <= 1'b0;
            err_trunc <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (wr_idx == '0) begin
                            da <= in_da;
                        end
                        if (closing) begin
                            last_idx  <= wr_idx;
                            state     <= ADDR;
                            phase     <= '0;
                            din       <= (wr_idx == '0) ? in_da[0] : da[0];
                            frame_n   <= 1'b0;
                            err_trunc <= !in_last;
                        end else begin
                            wr_idx <= wr_idx + 6'd1;
                        end
                    end
                end
                ADDR: begin
                    if (phase == 4'd3) begin
                        state <= PAD;
                        phase <= '0;
                        din   <= 1'b1;
                    end else begin
                        phase <= phase + 4'd1;
                        din   <= da[phase[1:0] + 2'd1];
                    end
                end
                PAD: begin
                    if (phase == PAD_LAST) begin
                        state   <= DATA;
                        rd_idx  <= '0;
                        bit_idx <= '0;
                        din     <= mem[0][0];
                        valid_n <= 1'b0;
                        frame_n <= 1'b0;
                    end else begin
                        phase <= phase + 4'd1;
                        din   <= 1'b1;
                    end
                end
                DATA: begin
                    if (final_bit) begin
                        state    <= DONE;
                        din      <= 1'b0;
                        frame_n  <= 1'b1;
                        valid_n  <= 1'b1;
                        pkt_done <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        rd_idx  <= nxt_idx;
                        bit_idx <= nxt_bit;
                        din     <= mem[nxt_idx[AW-1:0]][nxt_bit];
                        frame_n <= (nxt_idx == last_idx) && (nxt_bit == 3'd7);
                    end
                end
                DONE: begin
                    state    <= LOAD;
                    phase    <= '0;
                    wr_idx   <= '0;
                    rd_idx   <= '0;
                    last_idx <= '0;
                    bit_idx  <= '0;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_router_port_driver.sv
// Checks router_port_driver against a per-cycle expected trace built from
// packet contents: accept cycles, address, padding, payload bits, done.
module tb_router_port_driver;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PADC  = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic [3:0] in_da;
    logic       din;
    logic       frame_n;
    logic       valid_n;
    logic       busy;
    logic       pkt_done;
    logic       err_trunc;

    router_port_driver #(.DEPTH(DEPTH), .PAD_CYCLES(PADC)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_da     (in_da),
        .din       (din),
        .frame_n   (frame_n),
        .valid_n   (valid_n),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .err_trunc (err_trunc)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       vld;
        bit [7:0] data;
        bit       last;
        bit [3:0] da;
        bit       din;
        bit       frame_n;
        bit       valid_n;
        bit       rdy;
        bit       busy;
        bit       done;
        bit       trunc;
    } cyc_t;

    cyc_t trace[$];
    int   tests = 0;
    int   fails = 0;
    bit   stalls = 1'b0;

    task automatic chk(input string tag, input int idx, input logic obs, input bit exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s @%0d: observed %b expected %b", tag, idx, obs, exp_v);
        end
    endtask

    task automatic push(input bit vld, input bit [7:0] d, input bit lst, input bit [3:0] a,
                        input bit dn, input bit fr, input bit vn, input bit rdy,
                        input bit bsy, input bit dne, input bit tr);
        cyc_t c;
        c.vld = vld; c.data = d; c.last = lst; c.da = a;
        c.din = dn; c.frame_n = fr; c.valid_n = vn; c.rdy = rdy;
        c.busy = bsy; c.done = dne; c.trunc = tr;
        trace.push_back(c);
    endtask

    // Inputs during transmission are junk with in_valid high: none may be taken.
    task automatic add_packet(input bit [7:0] bytes[$], input bit [3:0] da, input bit trunc);
        int unsigned len = bytes.size();
        for (int unsigned k = 0; k < len; k++) begin
            int unsigned ns = stalls ? $urandom_range(0, 2) : 0;
            repeat (ns) push(1'b0, 8'($urandom), 1'($urandom), 4'($urandom),
                             1'b0, 1'b1, 1'b1, 1'b1, k > 0, 1'b0, 1'b0);
            push(1'b1, bytes[k], (k == len - 1) && !trunc, (k == 0) ? da : 4'($urandom),
                 1'b0, 1'b1, 1'b1, 1'b1, k > 0, 1'b0, 1'b0);
        end
        for (int unsigned i = 0; i < 4; i++)
            push(1'b1, 8'($urandom), 1'($urandom), 4'($urandom),
                 da[i], 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, (i == 0) && trunc);
        repeat (PADC) push(1'b1, 8'($urandom), 1'($urandom), 4'($urandom),
                           1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int unsigned j = 0; j < len; j++)
            for (int unsigned b = 0; b < 8; b++)
                push(1'b1, 8'($urandom), 1'($urandom), 4'($urandom),
                     bytes[j][b], (j == len - 1) && (b == 7), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b1, 8'($urandom), 1'($urandom), 4'($urandom),
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Called at posedge+1; runs n entries (all if n < 0) and leaves the bus idle.
    task automatic run_trace(input int n);
        int cnt = (n < 0) ? trace.size() : n;
        for (int i = 0; i < cnt; i++) begin
            cyc_t c = trace[i];
            in_valid = c.vld; in_data = c.data; in_last = c.last; in_da = c.da;
            @(negedge clock);
            chk("din",       i, din,       c.din);
            chk("frame_n",   i, frame_n,   c.frame_n);
            chk("valid_n",   i, valid_n,   c.valid_n);
            chk("in_ready",  i, in_ready,  c.rdy);
            chk("busy",      i, busy,      c.busy);
            chk("pkt_done",  i, pkt_done,  c.done);
            chk("err_trunc", i, err_trunc, c.trunc);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        trace.delete();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_din"},       0, din,       1'b0);
        chk({tag, "_frame_n"},   0, frame_n,   1'b1);
        chk({tag, "_valid_n"},   0, valid_n,   1'b1);
        chk({tag, "_in_ready"},  0, in_ready,  1'b1);
        chk({tag, "_busy"},      0, busy,      1'b0);
        chk({tag, "_pkt_done"},  0, pkt_done,  1'b0);
        chk({tag, "_err_trunc"}, 0, err_trunc, 1'b0);
    endtask

    initial begin
        bit [7:0] pk[$];
        bit [7:0] pk2[$];

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_da = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle("reset");
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle("post_reset");
        @(posedge clock);
        #1;

        // Single byte 0xA5 to address 3.
        pk.delete(); pk.push_back(8'hA5);
        add_packet(pk, 4'd3, 1'b0);
        run_trace(-1);

        // Three bytes to address 15.
        pk.delete(); pk.push_back(8'h01); pk.push_back(8'hFF); pk.push_back(8'h80);
        add_packet(pk, 4'd15, 1'b0);
        run_trace(-1);

        // DEPTH bytes without in_last, the next byte starts a new packet after pkt_done.
        pk.delete();
        for (int unsigned k = 0; k < DEPTH; k++) pk.push_back(8'($urandom));
        add_packet(pk, 4'($urandom), 1'b1);
        pk2.delete(); pk2.push_back(8'h3C);
        add_packet(pk2, 4'd9, 1'b0);
        run_trace(-1);

        // Back-to-back packets, in_valid held high, distinct addresses.
        pk.delete(); pk.push_back(8'h5A); pk.push_back(8'hC3);
        add_packet(pk, 4'd6, 1'b0);
        pk2.delete(); pk2.push_back(8'h96);
        add_packet(pk2, 4'd10, 1'b0);
        run_trace(-1);

        // Random packets with random input stalls.
        stalls = 1'b1;
        for (int p = 0; p < 20; p++) begin
            int unsigned len = $urandom_range(1, DEPTH);
            bit tr = (len == DEPTH) && ($urandom_range(0, 1) == 1);
            pk.delete();
            for (int unsigned k = 0; k < len; k++) pk.push_back(8'($urandom));
            add_packet(pk, 4'($urandom), tr);
        end
        run_trace(-1);
        stalls = 1'b0;

        // Reset during the payload of a two-byte packet.
        pk.delete(); pk.push_back(8'($urandom)); pk.push_back(8'($urandom));
        add_packet(pk, 4'd12, 1'b0);
        run_trace(2 + 4 + PADC + 5);
        chk("pre_reset_valid_n", 0, valid_n, 1'b0);
        chk("pre_reset_frame_n", 0, frame_n, 1'b0);
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        @(posedge clock);
        #1 reset = 1'b0;
        pk.delete(); pk.push_back(8'h71);
        add_packet(pk, 4'd5, 1'b0);
        run_trace(-1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
